// File: rtl/t03_mem_pkg.sv
// Shared types and constants for the t03 memory request unit.
// Holds the state encoding, the MMIO window base and the bus request record.
package t03_mem_pkg;

   localparam logic [31:0] MMIO_BASE = 32'hFFFF_FFFC;

   typedef logic [2:0] state_t;
   localparam state_t IDLE   = 3'd0;
   localparam state_t D_REQ  = 3'd1;
   localparam state_t D_WAIT = 3'd2;
   localparam state_t I_REQ  = 3'd3;
   localparam state_t I_WAIT = 3'd4;
   localparam state_t DONE   = 3'd5;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        read;
      logic        write;
   } bus_req_t;

   function automatic logic is_mmio(input logic [31:0] addr, input logic [31:0] base);
      return addr >= base;
   endfunction

endpackage

// File: rtl/t03_mem_request_unit_if.sv
// Bus-side signals between the request unit (master) and the memory bus adapter (slave).
interface t03_mem_request_unit_if;
   logic        bus_busy;
   logic [31:0] bus_dat_i;
   logic        bus_read;
   logic        bus_write;
   logic [31:0] bus_adr;
   logic [31:0] bus_dat_o;
   logic [3:0]  bus_sel;

   modport master (
      input  bus_busy, bus_dat_i,
      output bus_read, bus_write, bus_adr, bus_dat_o, bus_sel
   );

   modport slave (
      output bus_busy, bus_dat_i,
      input  bus_read, bus_write, bus_adr, bus_dat_o, bus_sel
   );
endinterface

// File: rtl/t03_req_timeout.sv
// WAIT-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle that would be the TIMEOUT_CYCLES-th one.
module t03_req_timeout #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic nrst,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   assign expire = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

   // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)       cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (enable) cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/t03_mem_request_unit.sv
// Serialises one data access and one instruction fetch per CPU step onto the
// shared memory bus, stalling the core until both results are back.
module t03_mem_request_unit #(
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] MMIO_BASE      = t03_mem_pkg::MMIO_BASE
) (
   input  logic                          clk,
   input  logic                          nrst,
   input  logic                          instr_req,
   input  logic [31:0]                   instr_addr,
   input  logic                          read_mem,
   input  logic                          write_mem,
   input  logic [31:0]                   data_address,
   input  logic [31:0]                   data_to_write,
   input  logic [3:0]                    data_sel,
   t03_mem_request_unit_if.master        bus,
   output logic [31:0]                   instr_out,
   output logic [31:0]                   data_from_mem,
   output logic                          stall,
   output logic                          err
);
   import t03_mem_pkg::*;

   state_t      state, state_nxt;
   bus_req_t    req_q;
   logic [31:0] fetch_adr_q, fetch_adr;
   logic        fetch_pend_q, is_load_q, busy_seen_q;
   logic        data_go, in_req, in_wait, done_ok, tmo_en, expire;

   assign data_go   = (read_mem | write_mem) & ~is_mmio(data_address, MMIO_BASE);
   assign in_req    = (state == D_REQ) || (state == I_REQ);
   assign in_wait   = (state == D_WAIT) || (state == I_WAIT);
   // Completion needs a busy pulse first, so a missed strobe ends in a timeout.
   assign done_ok   = in_wait & busy_seen_q & ~bus.bus_busy;
   assign tmo_en    = in_wait & ~done_ok;
   assign fetch_adr = (state == IDLE) ? instr_addr : fetch_adr_q;

   t03_req_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk    (clk),
      .nrst   (nrst),
      .clear  (in_req),
      .enable (tmo_en),
      .expire (expire)
   );

   assign bus.bus_adr   = req_q.adr;
   assign bus.bus_dat_o = req_q.dat;
   assign bus.bus_sel   = req_q.sel;
   assign bus.bus_read  = req_q.read  & in_req;
   assign bus.bus_write = req_q.write & in_req;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      stall     = in_req | in_wait;
      unique case (state)
         IDLE: begin
            stall = data_go | instr_req;
            if (data_go)        state_nxt = D_REQ;
            else if (instr_req) state_nxt = I_REQ;
         end
         D_REQ:  state_nxt = D_WAIT;
         D_WAIT: begin
            if (done_ok)     state_nxt = fetch_pend_q ? I_REQ : DONE;
            else if (expire) state_nxt = DONE;
         end
         I_REQ:  state_nxt = I_WAIT;
         I_WAIT: if (done_ok || expire) state_nxt = DONE;
         DONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state         <= IDLE;
         req_q         <= '0;
         fetch_adr_q   <= '0;
         fetch_pend_q  <= 1'b0;
         is_load_q     <= 1'b0;
         busy_seen_q   <= 1'b0;
         instr_out     <= '0;
         data_from_mem <= '0;
         err           <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            fetch_pend_q <= instr_req;
            fetch_adr_q  <= instr_addr;
         end
         if (state == IDLE && data_go) begin
            req_q     <= '{adr: data_address, dat: data_to_write, sel: data_sel,
                           read: read_mem & ~write_mem, write: write_mem};
            is_load_q <= ~write_mem;
         end else if (state_nxt == I_REQ) begin
            req_q <= '{adr: fetch_adr, dat: req_q.dat, sel: 4'hF, read: 1'b1, write: 1'b0};
         end
         if (in_req)                     busy_seen_q <= 1'b0;
         else if (in_wait && bus.bus_busy) busy_seen_q <= 1'b1;
         if (state == D_WAIT && done_ok && is_load_q) data_from_mem <= bus.bus_dat_i;
         if (state == I_WAIT && done_ok)              instr_out     <= bus.bus_dat_i;
         if (expire) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_t03_mem_request_unit.sv
// Directed plus random CPU steps against a transaction-level model of the
// request unit, with a behavioural bus adapter that plays back a busy/data plan.
module tb_t03_mem_request_unit;
   localparam int          TMO     = 8;
   localparam logic [31:0] MMIO_LO = 32'hFFFF_FFFC;

   typedef struct { logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; logic rd; logic wr; } txn_t;
   typedef struct { int busy; logic [31:0] rdata; } plan_t;
   typedef struct { logic ireq; logic [31:0] iaddr; logic rd; logic wr;
                    logic [31:0] daddr; logic [31:0] wdata; logic [3:0] sel; } step_t;

   logic        clk, nrst;
   logic        instr_req, read_mem, write_mem;
   logic [31:0] instr_addr, data_address, data_to_write;
   logic [3:0]  data_sel;
   logic [31:0] instr_out, data_from_mem;
   logic        stall, err;

   t03_mem_request_unit_if bus();

   t03_mem_request_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk           (clk),
      .nrst          (nrst),
      .instr_req     (instr_req),
      .instr_addr    (instr_addr),
      .read_mem      (read_mem),
      .write_mem     (write_mem),
      .data_address  (data_address),
      .data_to_write (data_to_write),
      .data_sel      (data_sel),
      .bus           (bus),
      .instr_out     (instr_out),
      .data_from_mem (data_from_mem),
      .stall         (stall),
      .err           (err)
   );

   int          total = 0;
   int          bad   = 0;
   txn_t        obs_q[$];
   plan_t       plan_q[$];
   logic [31:0] exp_instr = '0, exp_dfm = '0;
   logic        exp_err = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   // Adapter: logs each strobe, then raises busy for plan.busy cycles (never if <= 0).
   initial begin
      plan_t p;
      bus.bus_busy  = 1'b0;
      bus.bus_dat_i = 32'h5A5A_5A5A;
      forever begin
         @(negedge clk);
         if (nrst && (bus.bus_read === 1'b1 || bus.bus_write === 1'b1)) begin
            obs_q.push_back('{bus.bus_adr, bus.bus_dat_o, bus.bus_sel, bus.bus_read, bus.bus_write});
            if (plan_q.size() > 0) p = plan_q.pop_front();
            else                   p = '{1, 32'h0};
            if (p.busy > 0) begin
               @(posedge clk); #1;
               bus.bus_busy  = 1'b1;
               bus.bus_dat_i = ~p.rdata;
               repeat (p.busy) @(posedge clk);
               #1;
               bus.bus_busy  = 1'b0;
               bus.bus_dat_i = p.rdata;
               @(posedge clk); #1;
               bus.bus_dat_i = 32'h5A5A_5A5A;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_cpu();
      instr_req = 1'b0; read_mem = 1'b0; write_mem = 1'b0;
      instr_addr = '0; data_address = '0; data_to_write = '0; data_sel = '0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".read"},  32'(bus.bus_read),  32'h0);
      check({tag, ".write"}, 32'(bus.bus_write), 32'h0);
      check({tag, ".adr"},   bus.bus_adr,        32'h0);
      check({tag, ".dato"},  bus.bus_dat_o,      32'h0);
      check({tag, ".sel"},   32'(bus.bus_sel),   32'h0);
      check({tag, ".instr"}, instr_out,          32'h0);
      check({tag, ".dfm"},   data_from_mem,      32'h0);
      check({tag, ".stall"}, 32'(stall),         32'h0);
      check({tag, ".err"},   32'(err),           32'h0);
   endtask

   // Called at negedge+1 with the DUT idle; returns at negedge+1 with the DUT idle again.
   task automatic exec(input string name, input step_t s, input int b0, input logic [31:0] r0,
                       input int b1, input logic [31:0] r1);
      txn_t exp_q[$];
      int   exp_stall, got_stall, n;
      bit   has_data;
      has_data = (s.rd | s.wr) && (s.daddr < MMIO_LO);
      if (has_data) exp_q.push_back('{s.daddr, s.wdata, s.sel, s.rd & ~s.wr, s.wr});
      if (s.ireq)   exp_q.push_back('{s.iaddr, 32'h0, 4'hF, 1'b1, 1'b0});
      exp_stall = (exp_q.size() > 0) ? 1 : 0;
      n = exp_q.size();
      obs_q.delete();
      plan_q.delete();
      for (int i = 0; i < n; i++) begin
         int b;
         logic [31:0] r;
         b = (i == 0) ? b0 : b1;
         r = (i == 0) ? r0 : r1;
         plan_q.push_back('{b, r});
         if (b <= 0) begin
            exp_stall += 1 + TMO;
            exp_err = 1'b1;
            while (exp_q.size() > i + 1) void'(exp_q.pop_back());
            break;
         end
         exp_stall += 2 + b;
         if (has_data && i == 0) begin
            if (!s.wr) exp_dfm = r;
         end else begin
            exp_instr = r;
         end
      end

      instr_req = s.ireq; instr_addr = s.iaddr; read_mem = s.rd; write_mem = s.wr;
      data_address = s.daddr; data_to_write = s.wdata; data_sel = s.sel;
      #1;
      got_stall = 0;
      while (stall === 1'b1 && got_stall < 200) begin
         got_stall++;
         @(posedge clk); #1; clear_cpu();
         @(negedge clk); #1;
      end
      @(posedge clk); #1; clear_cpu();
      @(negedge clk); #1;

      check({name, ".ntxn"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check($sformatf("%s.t%0d.adr", name, i), obs_q[i].adr,       exp_q[i].adr);
         check($sformatf("%s.t%0d.sel", name, i), 32'(obs_q[i].sel),  32'(exp_q[i].sel));
         check($sformatf("%s.t%0d.rd",  name, i), 32'(obs_q[i].rd),   32'(exp_q[i].rd));
         check($sformatf("%s.t%0d.wr",  name, i), 32'(obs_q[i].wr),   32'(exp_q[i].wr));
         if (exp_q[i].wr) check($sformatf("%s.t%0d.dat", name, i), obs_q[i].dat, exp_q[i].dat);
      end
      check({name, ".stall_cycles"}, 32'(got_stall), 32'(exp_stall));
      check({name, ".instr_out"},    instr_out,      exp_instr);
      check({name, ".data_from_mem"}, data_from_mem, exp_dfm);
      check({name, ".err"},          32'(err),       32'(exp_err));
      plan_q.delete();
   endtask

   initial begin
      step_t s;
      nrst = 1'b0;
      clear_cpu();
      repeat (3) @(negedge clk);
      #1;
      check_quiet("reset");
      nrst = 1'b1;
      @(negedge clk); #1;
      check("idle.stall", 32'(stall), 32'h0);

      s = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
      exec("fetch", s, 3, 32'h00A0_0093, 0, 32'h0);

      s = '{1'b1, 32'h0000_0014, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF};
      exec("load_fetch", s, 2, 32'hDEAD_BEEF, 1, 32'h0000_0513);

      s = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3000, 32'h1234_5678, 4'b0011};
      exec("store", s, 2, 32'hFFFF_0000, 0, 32'h0);

      s = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hCAFE_0001, 4'hF};
      exec("mmio_store", s, 1, 32'h0, 0, 32'h0);

      s = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF};
      exec("mmio_load_fetch", s, 4, 32'h1111_2222, 0, 32'h0);

      s = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_4000, 32'hA5A5_0F0F, 4'b1100};
      exec("store_wins", s, 1, 32'h7777_7777, 0, 32'h0);

      s = '{1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'h0, 4'h1};
      exec("below_mmio", s, 5, 32'h0BAD_F00D, 5, 32'h0000_0073);

      for (int k = 0; k < 24; k++) begin
         s.ireq  = 1'($urandom_range(0, 1));
         s.iaddr = $urandom & 32'h0000_FFFC;
         s.rd    = 1'($urandom_range(0, 1));
         s.wr    = 1'($urandom_range(0, 1));
         s.daddr = ($urandom_range(0, 3) == 0) ? (MMIO_LO + 32'($urandom_range(0, 3)))
                                               : ($urandom & 32'h7FFF_FFFC);
         s.wdata = $urandom;
         s.sel   = 4'($urandom_range(1, 15));
         exec($sformatf("rnd%0d", k), s, $urandom_range(1, 5), $urandom,
              $urandom_range(1, 5), $urandom);
      end

      s = '{1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
      exec("timeout", s, 0, 32'h1357_9BDF, 0, 32'h0);

      s = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF};
      exec("err_sticky", s, 1, 32'h2468_ACE0, 0, 32'h0);

      // Reset while the adapter is still busy with a load.
      obs_q.delete();
      plan_q.push_back('{5, 32'h9999_9999});
      read_mem = 1'b1; data_address = 32'h0000_6000; data_sel = 4'hF;
      @(posedge clk); #1; clear_cpu();
      @(posedge clk);
      @(negedge clk);
      nrst = 1'b0;
      #1;
      check_quiet("mid_reset");
      repeat (8) @(negedge clk);
      nrst = 1'b1;
      exp_instr = '0; exp_dfm = '0; exp_err = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check($sformatf("post_reset%0d.stall", k), 32'(stall), 32'h0);
      end
      check("post_reset.ntxn", 32'(obs_q.size()), 32'h1);
      plan_q.delete();

      s = '{1'b1, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'hF};
      exec("after_reset", s, 2, 32'h0F0F_F0F0, 3, 32'h0000_00B7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
